// File: rtl/output_argmax_if.sv
// Score stream in, prediction stream out, plus the run-complete flag.
interface output_argmax_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLASS_W = 4,
  parameter int unsigned IMAGE_W = 4
);
  logic               score_valid;
  logic               score_ready;
  logic [DATA_W-1:0]  score_data;
  logic               pred_valid;
  logic               pred_ready;
  logic [CLASS_W-1:0] pred_class;
  logic [IMAGE_W-1:0] pred_image;
  logic [DATA_W-1:0]  pred_score;
  logic               done;

  // Environment side: produces scores, consumes predictions.
  modport master (
    output score_valid, score_data, pred_ready,
    input  score_ready, pred_valid, pred_class, pred_image, pred_score, done
  );

  // Block side: consumes scores, produces predictions.
  modport slave (
    input  score_valid, score_data, pred_ready,
    output score_ready, pred_valid, pred_class, pred_image, pred_score, done
  );
endinterface

// File: rtl/output_argmax.sv
// Per-image argmax over a stream of signed class scores, buffered predictions out.
module output_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned NUM_IMAGES  = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic           clk,
  input  logic           reset,
  output_argmax_if.slave bus
);

  localparam int unsigned CLASS_W = 4;
  localparam int unsigned IMAGE_W = 4;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [IMAGE_W-1:0] LAST_IMAGE = IMAGE_W'(NUM_IMAGES - 1);
  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(FIFO_DEPTH);

  // Stream position and running maximum
  logic [CLASS_W-1:0]       class_cnt;
  logic [IMAGE_W-1:0]       image_cnt;
  logic signed [DATA_W-1:0] best;
  logic [CLASS_W-1:0]       best_idx;
  logic                     in_done;
  logic                     done_q;

  // Prediction buffer
  logic [CLASS_W-1:0] mem_class [FIFO_DEPTH];
  logic [IMAGE_W-1:0] mem_image [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_score [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // Combinational helpers
  logic                     fifo_full_c;
  logic                     fifo_empty_c;
  logic                     last_beat_c;
  logic                     ready_c;
  logic                     accept_c;
  logic                     pop_c;
  logic                     push_c;
  logic                     beat_wins_c;
  logic signed [DATA_W-1:0] final_score_c;
  logic [CLASS_W-1:0]       final_idx_c;

  // Handshake qualifiers and the result of the image including the current beat
  always_comb begin
    fifo_full_c   = (count == FULL_CNT);
    fifo_empty_c  = (count == '0);
    last_beat_c   = (class_cnt == LAST_CLASS);
    // Only the closing beat of an image needs a free slot; pops do not count
    // toward that slot so pred_ready never reaches score_ready.
    ready_c       = !in_done && !(last_beat_c && fifo_full_c);
    accept_c      = bus.score_valid && ready_c;
    pop_c         = !fifo_empty_c && bus.pred_ready;
    push_c        = accept_c && last_beat_c;
    // Strict compare: ties keep the earlier (lower) class index.
    beat_wins_c   = $signed(bus.score_data) > best;
    final_score_c = best;
    final_idx_c   = best_idx;
    if (beat_wins_c) begin
      final_score_c = $signed(bus.score_data);
      final_idx_c   = class_cnt;
    end
  end

  // Class/image position and end-of-input flag
  always_ff @(posedge clk) begin
    if (reset) begin
      class_cnt <= '0;
      image_cnt <= '0;
      in_done   <= 1'b0;
    end else if (accept_c) begin
      if (last_beat_c) begin
        class_cnt <= '0;
        if (image_cnt == LAST_IMAGE) begin
          in_done <= 1'b1;
        end else begin
          image_cnt <= image_cnt + IMAGE_W'(1);
        end
      end else begin
        class_cnt <= class_cnt + CLASS_W'(1);
      end
    end
  end

  // Running maximum within the current image
  always_ff @(posedge clk) begin
    if (reset) begin
      best     <= '0;
      best_idx <= '0;
    end else if (accept_c) begin
      if (class_cnt == '0) begin
        best     <= $signed(bus.score_data);
        best_idx <= '0;
      end else if (beat_wins_c) begin
        best     <= $signed(bus.score_data);
        best_idx <= class_cnt;
      end
    end
  end

  // Buffer storage: write the finished prediction at the tail
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_class <= '{default: '0};
      mem_image <= '{default: '0};
      mem_score <= '{default: '0};
    end else if (push_c) begin
      mem_class[wr_ptr] <= final_idx_c;
      mem_image[wr_ptr] <= image_cnt;
      mem_score[wr_ptr] <= final_score_c;
    end
  end

  // Buffer pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Run complete once the final image's prediction leaves the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (pop_c && in_done && (mem_image[rd_ptr] == LAST_IMAGE)) begin
      done_q <= 1'b1;
    end
  end

  assign bus.score_ready = ready_c;
  assign bus.pred_valid  = !fifo_empty_c;
  assign bus.pred_class  = mem_class[rd_ptr];
  assign bus.pred_image  = mem_image[rd_ptr];
  assign bus.pred_score  = mem_score[rd_ptr];
  assign bus.done        = done_q;

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Downstream of the inference core's stage-2 output.
- Consumes the stream of signed 16-bit class scores (10 per image, class 0..9 in order, images in order) and finds the highest score per image.
- Emits a predicted digit, the image index and the winning score through a 2-entry output buffer with valid/ready handshake.
- Asserts done once all NUM_IMAGES predictions have been taken by the consumer.

Parameters:
- NUM_CLASSES, 10, scores per image (class index width 4 bits).
- NUM_IMAGES, 10, images per run (image index width 4 bits).
- DATA_W, 16, score width, two's-complement signed.
- FIFO_DEPTH, 2, prediction buffer entries.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- score_valid  in  1  score_data valid this cycle.
- score_ready  out  1  block accepts score this cycle.
- score_data  in  DATA_W  signed class score.
- pred_valid  out  1  prediction available at buffer head.
- pred_ready  in  1  consumer takes head this cycle.
- pred_class  out  4  winning class index of head entry.
- pred_image  out  4  image index of head entry.
- pred_score  out  DATA_W  winning score of head entry.
- done  out  1  all predictions consumed; sticky until reset.

Behaviour:
- Reset values: score_ready=1, pred_valid=0, pred_class=0, pred_image=0, pred_score=0, done=0. Internal class_cnt=0, image_cnt=0, best=0, best_idx=0, FIFO empty, in_done=0.
- Accept: score_valid && score_ready. Pop: pred_valid && pred_ready.
- On accept, class_cnt increments and wraps NUM_CLASSES-1 -> 0. On wrap, image_cnt increments. If image_cnt was NUM_IMAGES-1, in_done is set instead.
- Running max:
  - class_cnt==0: best<=data, best_idx<=0.
  - Otherwise update only if data > best (signed, strict). Ties keep the lower class index.
- Last class (class_cnt==NUM_CLASSES-1): the final result is computed including the current beat and pushed as {image_cnt, idx, score} in the same edge.
  - pred_valid rises 1 cycle after that accept when the FIFO was empty.
- score_ready = !in_done && !(class_cnt==NUM_CLASSES-1 && fifo_full).
  - Beats for classes 0..8 are accepted even when the FIFO is full.
  - No combinational path from pred_ready to score_ready: a same-cycle pop does not free a slot for a push.
- A push and a pop in the same cycle are both honoured. Count is unchanged when the FIFO is non-empty.
- The FIFO preserves order. Outputs show the head entry. pred_class, pred_image and pred_score hold their values while pred_valid && !pred_ready.
- done:
  - Rises the cycle after the pop of the entry with image index NUM_IMAGES-1, with in_done=1.
  - Stays high until reset.
  - While in_done, score_valid is ignored and no state changes.
- Reset mid-image or mid-run discards the partial max and all buffered predictions. The next accepted score is class 0 of image 0.
- Scores arriving while score_ready=0 are not consumed; the source must hold them.

Test Plan:
- Single image, scores class0..9 = -5,3,100,7,0,-1,99,100,2,-32768, pred_ready=1 -> one cycle after the 10th accept: pred_valid=1, pred_class=2, pred_image=0, pred_score=100; pred_valid drops the next cycle.
- Signed/tie checks:
  - All ten scores 0x8000 except 0xFFFF at class 9 -> class 9.
  - 0x7FFF at class 1, 0xFFFF elsewhere -> class 1, score 0x7FFF.
  - All zeros -> class 0.
- Backpressure: pred_ready=0, stream 3 images back-to-back:
  - Images 0 and 1 are buffered.
  - score_ready drops while image 2's class-9 beat is presented and stays low until a pop.
  - Raising pred_ready delivers images 0, 1, 2 in order with correct classes.
- Full run, 10 images with known argmaxes (e.g. 7,2,1,0,4,1,4,9,5,9), pred_ready=1:
  - Ten predictions match.
  - done=1 one cycle after the 10th pop.
  - score_ready=0 afterwards; extra score_valid beats change nothing.
- Reset after class 5 of image 3, with 1 prediction buffered -> pred_valid=0, done=0. A fresh 10-score image yields pred_image=0.
- Simultaneous push/pop: FIFO holding 1 entry, pred_ready=1 in the cycle image k's last beat is accepted -> head advances to image k the next cycle with no loss or duplication.
